muldiv_sched: RTL and testbench
===============================

# muldiv_sched

Two-requester scheduler for the N-bit HI/LO multiply/divide core. It arbitrates operation requests round-robin and drives the core's `F`/`a`/`b` inputs through a fixed issue/readback sequence. It reads HI and LO back over the core's `y` view port and returns both to the winning requester with a valid/ready response. It sits between the core and its users, and zeroes HI/LO after every reset because the core itself has no reset.

## Interface
- `N`, default 3: operand, HI and LO width; must match the core instance.
- `clk`  in  1: single clock; all state updates on posedge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  2: per-requester request valid (bit i = requester i).
- `req_ready`  out  2: per-requester accept; at most one bit high per cycle.
- `req_op0`, `req_op1`  in  2 each: operation code. 00 = load HI, 01 = load LO, 10 = MULT, 11 = DIV.
- `req_a0`, `req_a1`, `req_b0`, `req_b1`  in  N each: operands.
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: response accept.
- `rsp_id`  out  1: requester index of the response.
- `rsp_hi`, `rsp_lo`  out  N each: HI/LO after the operation.
- `rsp_err`  out  1: divide-by-zero flag (see Configuration).
- `core_F`  out  4: core function code, registered.
- `core_a`, `core_b`  out  N each: core operands, registered.
- `core_y`  in  N: core view output.

## Operation
- Op code to `core_F` mapping: 00 → 0001, 01 → 0011, 10 → 1000, 11 → 1010. Idle/view code is 0000.
- States and the `core_F` driven in each:
  - INIT_HI: `core_F` = 0001, `core_a` = 0.
  - INIT_LO: `core_F` = 0011, `core_a` = 0.
  - IDLE: `core_F` = 0000.
  - ISSUE: mapped code, latched a/b.
  - RD_HI: `core_F` = 0000; capture `core_y` → `rsp_hi` at cycle end.
  - RD_LO: `core_F` = 0010; capture `core_y` → `rsp_lo` at cycle end.
  - RESP.
- Transitions:
  - INIT_HI → INIT_LO → IDLE, unconditional.
  - IDLE → ISSUE when any `req_valid` is high.
  - ISSUE → RD_HI → RD_LO → RESP, unconditional.
  - RESP → IDLE on `rsp_valid && rsp_ready`.
- Acceptance: `req_ready` asserts only in IDLE, combinationally, for the granted requester whose `req_valid` is high. The handshake completes in that cycle; op, a, b and id are latched.
- Arbitration: round-robin using a last-grant pointer.
  - If one requester is valid, it wins.
  - If both are valid, the requester not granted last wins.
  - The pointer resets to 1, so requester 0 wins the first tie.
- `core_F`, `core_a`, `core_b` are registered from the next state. The value shown for a state is present on the pins throughout that state.
- `core_a`/`core_b` hold their last value outside ISSUE and INIT. They are zero after reset.
- `rsp_hi`, `rsp_lo`, `rsp_id`, `rsp_err` are stable from `rsp_valid` rise until the handshake completes.
- No new request is accepted while in ISSUE through RESP. `req_valid` held high simply waits.
- Load ops also return HI and LO; the unwritten register shows its held value.
- Reset mid-operation aborts any in-flight op with no response. The controller re-enters INIT_HI and re-zeroes HI/LO.

## Timing
- Reset values:
  - state = INIT_HI
  - `core_F` = 0001
  - `core_a` = 0, `core_b` = 0
  - `req_ready` = 00
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_hi` = 0, `rsp_lo` = 0, `rsp_err` = 0
  - grant pointer = 1
- Post-reset: cycle 0 INIT_HI, cycle 1 INIT_LO, first accept possible in cycle 2.
- Accept in cycle T:
  - ISSUE in T+1; core HI/LO update at the end of T+1.
  - RD_HI in T+2, RD_LO in T+3.
  - `rsp_valid` high from T+4.
- With `rsp_ready` held high: one op per 5 cycles, so the next accept is at T+5.
- `rsp_ready` low holds RESP indefinitely; all response outputs remain constant.

## Configuration
- `MULDIV_SCHED_DZ_TRAP_EN`:
  - Defined: a DIV with latched b == 0 skips ISSUE, going IDLE → RD_HI, so `core_F` never shows 1010 with `core_b` == 0. The response carries the unchanged HI/LO, `rsp_err` = 1, and latency of accept + 3.
  - Undefined: the op is issued normally (the core holds its registers), `rsp_err` is tied 0, and latency is accept + 4.

## Test plan
- Reset release:
  - `core_F` sequence is 0001, 0011, then 0000, with `core_a` = 0.
  - `req_ready` first asserts in cycle 2.
  - A subsequent load-HI a=0 returns hi=0, lo=0.
- Requester 0 MULT a=5, b=6, accepted at T: `rsp_valid` at T+4 with id=0, hi=3, lo=6.
- Requester 1 DIV a=7, b=3: response id=1, hi=1 (remainder), lo=2 (quotient).
- Arbitration:
  - Both valid from reset: grants go 0, then 1; `req_ready` is never 11.
  - Requester 0 sole for one op, then both valid: requester 1 is granted.
- Backpressure: `rsp_ready` low for 3 cycles in RESP. `rsp_*` is held, `req_ready` stays 00, and the next accept comes in the cycle after the handshake.
- DIV a=7, b=0 after MULT 5×6:
  - With the macro: hi=3, lo=6, err=1 at accept+3, and no 1010 issued.
  - Without the macro: hi=3, lo=6, err=0 at accept+4.
- Reset asserted during RD_HI: no response; the INIT sequence reruns and the next op returns correct values.

Source files
------------

// File: rtl/muldiv_sched.sv
`timescale 1ns/1ps
// muldiv_sched: two-requester round-robin front end for the N-bit HI/LO
// multiply/divide core. Drives the core's F/a/b through INIT (zero HI/LO),
// ISSUE, HI readback and LO readback, then returns HI/LO on a valid/ready
// response channel.
// Optional build macro MULDIV_SCHED_DZ_TRAP_EN: when defined, a DIV whose
// latched divisor is zero is never issued to the core; the unchanged HI/LO
// come back with rsp_err set, one cycle earlier. When undefined the DIV is
// issued as-is and rsp_err stays 0.

module muldiv_sched #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [1:0]   req_op0,
    input  logic [1:0]   req_op1,
    input  logic [N-1:0] req_a0,
    input  logic [N-1:0] req_a1,
    input  logic [N-1:0] req_b0,
    input  logic [N-1:0] req_b1,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_hi,
    output logic [N-1:0] rsp_lo,
    output logic         rsp_err,

    output logic [3:0]   core_F,
    output logic [N-1:0] core_a,
    output logic [N-1:0] core_b,
    input  logic [N-1:0] core_y
);

    localparam int unsigned FW  = 4;
    localparam int unsigned OPW = 2;

    // Core function codes
    localparam logic [FW-1:0] F_VIEW_HI = 4'b0000;
    localparam logic [FW-1:0] F_LD_HI   = 4'b0001;
    localparam logic [FW-1:0] F_VIEW_LO = 4'b0010;
    localparam logic [FW-1:0] F_LD_LO   = 4'b0011;
    localparam logic [FW-1:0] F_MULT    = 4'b1000;
    localparam logic [FW-1:0] F_DIV     = 4'b1010;

    // Request op codes
    localparam logic [OPW-1:0] OP_LD_HI = 2'b00;
    localparam logic [OPW-1:0] OP_LD_LO = 2'b01;
    localparam logic [OPW-1:0] OP_MULT  = 2'b10;
    localparam logic [OPW-1:0] OP_DIV   = 2'b11;

    typedef enum logic [2:0] {
        S_INIT_HI = 3'd0,
        S_INIT_LO = 3'd1,
        S_IDLE    = 3'd2,
        S_ISSUE   = 3'd3,
        S_RD_HI   = 3'd4,
        S_RD_LO   = 3'd5,
        S_RESP    = 3'd6
    } state_t;

    state_t         state;
    state_t         state_n;

    logic           last_gnt;
    logic           gnt_c;
    logic           any_valid_c;
    logic           accept_c;
    logic           dz_c;

    logic [OPW-1:0] sel_op_c;
    logic [N-1:0]   sel_a_c;
    logic [N-1:0]   sel_b_c;

    logic [FW-1:0]  core_f_n;
    logic [N-1:0]   core_a_n;
    logic [N-1:0]   core_b_n;

    // Request op code to core function code
    function automatic logic [FW-1:0] op_to_f(input logic [OPW-1:0] op);
        logic [FW-1:0] f;
        case (op)
            OP_LD_HI: f = F_LD_HI;
            OP_LD_LO: f = F_LD_LO;
            OP_MULT:  f = F_MULT;
            OP_DIV:   f = F_DIV;
            default:  f = F_VIEW_HI;
        endcase
        return f;
    endfunction

    // Round-robin winner: a lone requester wins, a tie goes to the one not granted last
    always_comb begin
        any_valid_c = |req_valid;
        if (req_valid == 2'b11) begin
            gnt_c = ~last_gnt;
        end else begin
            gnt_c = req_valid[1];
        end
    end

    // Operand mux for the current winner
    always_comb begin
        sel_op_c = req_op0;
        sel_a_c  = req_a0;
        sel_b_c  = req_b0;
        if (gnt_c) begin
            sel_op_c = req_op1;
            sel_a_c  = req_a1;
            sel_b_c  = req_b1;
        end
    end

    // Combinational accept: only in IDLE, one-hot to the winner
    always_comb begin
        req_ready = 2'b00;
        accept_c  = (state == S_IDLE) && any_valid_c;
        if (accept_c) begin
            req_ready = gnt_c ? 2'b10 : 2'b01;
        end
    end

`ifdef MULDIV_SCHED_DZ_TRAP_EN
    // Divide-by-zero trap: flag an accepted DIV with a zero divisor
    always_comb begin
        dz_c = accept_c && (sel_op_c == OP_DIV) && (sel_b_c == '0);
    end
`else
    // Divide-by-zero goes to the core unchanged; never flagged
    always_comb begin
        dz_c = 1'b0;
    end
`endif

    // Next state and next core pin values (core pins follow the next state)
    always_comb begin
        state_n  = state;
        core_f_n = F_VIEW_HI;
        core_a_n = core_a;
        core_b_n = core_b;

        case (state)
            S_INIT_HI: state_n = S_INIT_LO;
            S_INIT_LO: state_n = S_IDLE;
            S_IDLE: begin
                if (accept_c) begin
                    state_n = dz_c ? S_RD_HI : S_ISSUE;
                end
            end
            S_ISSUE:   state_n = S_RD_HI;
            S_RD_HI:   state_n = S_RD_LO;
            S_RD_LO:   state_n = S_RESP;
            S_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_n = S_IDLE;
                end
            end
            default:   state_n = S_INIT_HI;
        endcase

        case (state_n)
            S_INIT_HI: begin
                core_f_n = F_LD_HI;
                core_a_n = '0;
                core_b_n = '0;
            end
            S_INIT_LO: begin
                core_f_n = F_LD_LO;
                core_a_n = '0;
                core_b_n = '0;
            end
            S_ISSUE: begin
                core_f_n = op_to_f(sel_op_c);
                core_a_n = sel_a_c;
                core_b_n = sel_b_c;
            end
            S_RD_LO:  core_f_n = F_VIEW_LO;
            default:  core_f_n = F_VIEW_HI;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT_HI;
        end else begin
            state <= state_n;
        end
    end

    // Registered core drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_F <= F_LD_HI;
            core_a <= '0;
            core_b <= '0;
        end else begin
            core_F <= core_f_n;
            core_a <= core_a_n;
            core_b <= core_b_n;
        end
    end

    // Last-grant pointer; reset to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
        end else if (accept_c) begin
            last_gnt <= gnt_c;
        end
    end

    // Response id/err latched at accept; held until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id  <= 1'b0;
            rsp_err <= 1'b0;
        end else if (accept_c) begin
            rsp_id  <= gnt_c;
            rsp_err <= dz_c;
        end
    end

    // HI/LO readback capture from the core view port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_hi <= '0;
            rsp_lo <= '0;
        end else begin
            if (state == S_RD_HI) begin
                rsp_hi <= core_y;
            end
            if (state == S_RD_LO) begin
                rsp_lo <= core_y;
            end
        end
    end

    // Response valid tracks residence in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= (state_n == S_RESP);
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
`timescale 1ns/1ps
// Bench for muldiv_sched: behavioural core model on the core pins, plus a
// transaction-level reference (HI/LO arithmetic and round-robin pointer).

module tb_muldiv_sched;

    localparam int unsigned N  = 3;
    localparam int unsigned W2 = 2 * N;
`ifdef MULDIV_SCHED_DZ_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [1:0]   req_op0, req_op1;
    logic [N-1:0] req_a0, req_a1, req_b0, req_b1;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [N-1:0] rsp_hi, rsp_lo;
    logic [3:0]   core_F;
    logic [N-1:0] core_a, core_b, core_y;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int both_ready_seen = 0;
    int dz_issue_seen = 0;

    // Reference model state
    logic [N-1:0] m_hi, m_lo;
    logic         m_last;

    // Arbitration scoreboard for the two-requester runs
    int           sb_gnt[2];
    int           sb_id[2];
    logic [N-1:0] sb_hi[2], sb_lo[2], sb_ehi[2], sb_elo[2];
    bit           sb_to;

    always #5 clk = ~clk;

    muldiv_sched #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err),
        .core_F(core_F), .core_a(core_a), .core_b(core_b), .core_y(core_y)
    );

    // Behavioural HI/LO multiply/divide core (no reset)
    logic [N-1:0] c_hi, c_lo;
    always @(posedge clk) begin
        case (core_F)
            4'b0001: c_hi <= core_a;
            4'b0011: c_lo <= core_a;
            4'b1000: {c_hi, c_lo} <= W2'(core_a) * W2'(core_b);
            4'b1010: if (core_b != '0) begin
                c_lo <= core_a / core_b;
                c_hi <= core_a % core_b;
            end
            default: ;
        endcase
    end
    assign core_y = (core_F == 4'b0010) ? c_lo : c_hi;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (req_ready == 2'b11) both_ready_seen <= both_ready_seen + 1;
    always @(posedge clk) if (rst_n && core_F == 4'b1010 && core_b == '0) dz_issue_seen <= dz_issue_seen + 1;

    task automatic model_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        int p;
        case (op)
            2'b00: m_hi = a;
            2'b01: m_lo = a;
            2'b10: begin
                p = int'(a) * int'(b);
                m_hi = N'(p >> N);
                m_lo = N'(p);
            end
            default: if (b != '0) begin
                m_hi = a % b;
                m_lo = a / b;
            end
        endcase
    endtask

    task automatic model_reset();
        m_hi = '0;
        m_lo = '0;
        m_last = 1'b1;
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        if (id == 0) begin
            req_op0 = op; req_a0 = a; req_b0 = b;
        end else begin
            req_op1 = op; req_a1 = a; req_b1 = b;
        end
    endtask

    // Hold reset low for two cycles; caller releases it
    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Drive one request from a lone requester and collect its response
    task automatic run_op(input int id, input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                          output int gnt, output int lat, output logic [N-1:0] hi, output logic [N-1:0] lo,
                          output logic err, output logic rid, output bit to);
        int acc;
        bit got;
        to = 1'b0; gnt = -1; lat = -1; hi = '0; lo = '0; err = 1'b0; rid = 1'b0;
        set_req(id, op, a, b);
        req_valid[id] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (req_ready != 2'b00) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            to = 1'b1;
            req_valid = 2'b00;
            return;
        end
        gnt = req_ready[1] ? 1 : 0;
        acc = cyc;
        @(negedge clk);
        req_valid[id] = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (rsp_valid) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            to = 1'b1;
            return;
        end
        lat = cyc - acc;
        hi = rsp_hi; lo = rsp_lo; err = rsp_err; rid = rsp_id;
        @(negedge clk);
    endtask

    // Both requesters valid; record two grants and two responses
    task automatic serve_both(input logic [1:0] o0, input logic [N-1:0] a0, input logic [N-1:0] b0,
                              input logic [1:0] o1, input logic [N-1:0] a1, input logic [N-1:0] b1,
                              input bit release_rst);
        int ng, nr, pend, g;
        set_req(0, o0, a0, b0);
        set_req(1, o1, a1, b1);
        req_valid = 2'b11;
        if (release_rst) rst_n = 1'b1;
        ng = 0; nr = 0; pend = -1;
        for (int k = 0; k < 40 && nr < 2; k++) begin
            if (pend >= 0) begin
                req_valid[pend] = 1'b0;
                pend = -1;
            end
            #1;
            if (req_ready != 2'b00 && ng < 2) begin
                g = req_ready[1] ? 1 : 0;
                sb_gnt[ng] = g;
                m_last = g[0];
                if (g == 1) model_op(o1, a1, b1);
                else model_op(o0, a0, b0);
                sb_ehi[ng] = m_hi;
                sb_elo[ng] = m_lo;
                ng++;
                pend = g;
            end
            if (rsp_valid && nr < 2) begin
                sb_id[nr] = int'(rsp_id);
                sb_hi[nr] = rsp_hi;
                sb_lo[nr] = rsp_lo;
                nr++;
            end
            @(negedge clk);
        end
        sb_to = (nr < 2) || (ng < 2);
        req_valid = 2'b00;
    endtask

    task automatic test_reset();
        int acc, lat;
        bit got;
        do_reset();
        set_req(0, 2'b00, '0, '0);
        req_valid = 2'b01;
        #1;
        checks++; if (core_F !== 4'b0001) begin errors++; $display("FAIL reset_core_F got=%b exp=0001", core_F); end
        checks++; if ({core_a, core_b} !== '0) begin errors++; $display("FAIL reset_core_ab got=%0h exp=0", {core_a, core_b}); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        checks++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b000) begin errors++; $display("FAIL reset_rsp_flags got=%b exp=000", {rsp_valid, rsp_id, rsp_err}); end
        checks++; if ({rsp_hi, rsp_lo} !== '0) begin errors++; $display("FAIL reset_rsp_data got=%0h exp=0", {rsp_hi, rsp_lo}); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if ({core_F, req_ready} !== 6'b0001_00) begin errors++; $display("FAIL init_cyc0 got=%b exp=000100", {core_F, req_ready}); end
        checks++; if (core_a !== '0) begin errors++; $display("FAIL init_cyc0_a got=%0d exp=0", core_a); end
        @(negedge clk); #1;
        checks++; if ({core_F, req_ready} !== 6'b0011_00) begin errors++; $display("FAIL init_cyc1 got=%b exp=001100", {core_F, req_ready}); end
        checks++; if (core_a !== '0) begin errors++; $display("FAIL init_cyc1_a got=%0d exp=0", core_a); end
        @(negedge clk); #1;
        checks++; if ({core_F, req_ready} !== 6'b0000_01) begin errors++; $display("FAIL init_cyc2 got=%b exp=000001", {core_F, req_ready}); end
        acc = cyc;
        m_last = 1'b0;
        model_op(2'b00, '0, '0);
        @(negedge clk);
        req_valid = 2'b00;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (rsp_valid) got = 1'b1;
            else @(negedge clk);
        end
        lat = cyc - acc;
        checks++; if (!got) begin errors++; $display("FAIL reset_first_rsp got=timeout exp=rsp_valid"); end
        checks++; if ({rsp_hi, rsp_lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL reset_first_data got=%0h exp=%0h", {rsp_hi, rsp_lo}, {m_hi, m_lo}); end
        checks++; if (lat != 4) begin errors++; $display("FAIL reset_first_lat got=%0d exp=4", lat); end
        @(negedge clk);
    endtask

    task automatic test_mult();
        int gnt, lat; logic [N-1:0] hi, lo; logic err, rid; bit to;
        run_op(0, 2'b10, 3'd5, 3'd6, gnt, lat, hi, lo, err, rid, to);
        m_last = 1'b0;
        model_op(2'b10, 3'd5, 3'd6);
        checks++; if (to) begin errors++; $display("FAIL mult_timeout got=timeout exp=response"); end
        checks++; if (lat != 4) begin errors++; $display("FAIL mult_lat got=%0d exp=4", lat); end
        checks++; if ({rid, hi, lo} !== {1'b0, m_hi, m_lo}) begin errors++; $display("FAIL mult_rsp got=%0d/%0d/%0d exp=0/%0d/%0d", rid, hi, lo, m_hi, m_lo); end
        checks++; if ({hi, lo} !== {3'd3, 3'd6}) begin errors++; $display("FAIL mult_value got=%0d/%0d exp=3/6", hi, lo); end
    endtask

    task automatic test_div();
        int gnt, lat; logic [N-1:0] hi, lo; logic err, rid; bit to;
        run_op(1, 2'b11, 3'd7, 3'd3, gnt, lat, hi, lo, err, rid, to);
        m_last = 1'b1;
        model_op(2'b11, 3'd7, 3'd3);
        checks++; if (to) begin errors++; $display("FAIL div_timeout got=timeout exp=response"); end
        checks++; if (gnt != 1) begin errors++; $display("FAIL div_grant got=%0d exp=1", gnt); end
        checks++; if ({rid, hi, lo, err} !== {1'b1, m_hi, m_lo, 1'b0}) begin errors++; $display("FAIL div_rsp got=%0d/%0d/%0d/%0d exp=1/%0d/%0d/0", rid, hi, lo, err, m_hi, m_lo); end
        checks++; if ({hi, lo} !== {3'd1, 3'd2}) begin errors++; $display("FAIL div_value got=%0d/%0d exp=1/2", hi, lo); end
    endtask

    task automatic test_arbitration();
        int gnt, lat, snap; logic [N-1:0] hi, lo; logic err, rid; bit to;
        snap = both_ready_seen;
        do_reset();
        serve_both(2'b10, 3'd2, 3'd3, 2'b01, 3'd5, 3'd0, 1'b1);
        checks++; if (sb_to) begin errors++; $display("FAIL arb_tie_timeout got=timeout exp=two responses"); end
        checks++; if (sb_gnt[0] != 0 || sb_gnt[1] != 1) begin errors++; $display("FAIL arb_tie_order got=%0d,%0d exp=0,1", sb_gnt[0], sb_gnt[1]); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (sb_id[i] != sb_gnt[i] || sb_hi[i] !== sb_ehi[i] || sb_lo[i] !== sb_elo[i]) begin
                errors++;
                $display("FAIL arb_tie_rsp%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, sb_id[i], sb_hi[i], sb_lo[i], sb_gnt[i], sb_ehi[i], sb_elo[i]);
            end
        end
        run_op(0, 2'b00, 3'd4, 3'd0, gnt, lat, hi, lo, err, rid, to);
        m_last = 1'b0;
        model_op(2'b00, 3'd4, 3'd0);
        checks++; if (to || gnt != 0 || {hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL arb_sole got=%0d/%0d/%0d exp=0/%0d/%0d", gnt, hi, lo, m_hi, m_lo); end
        serve_both(2'b01, 3'd1, 3'd0, 2'b10, 3'd7, 3'd7, 1'b0);
        checks++; if (sb_to || sb_gnt[0] != 1 || sb_gnt[1] != 0) begin errors++; $display("FAIL arb_after_sole got=%0d,%0d exp=1,0", sb_gnt[0], sb_gnt[1]); end
        checks++; if (sb_hi[1] !== sb_ehi[1] || sb_lo[1] !== sb_elo[1]) begin errors++; $display("FAIL arb_after_sole_data got=%0d/%0d exp=%0d/%0d", sb_hi[1], sb_lo[1], sb_ehi[1], sb_elo[1]); end
        checks++; if (both_ready_seen != snap) begin errors++; $display("FAIL arb_ready_onehot got=%0d exp=%0d", both_ready_seen, snap); end
    endtask

    task automatic test_backpressure();
        int acc, lat;
        bit got;
        rsp_ready = 1'b0;
        set_req(0, 2'b10, 3'd3, 3'd5);
        req_valid = 2'b01;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (req_ready != 2'b00) got = 1'b1;
            else @(negedge clk);
        end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_accept got=%b exp=01", req_ready); end
        m_last = 1'b0;
        model_op(2'b10, 3'd3, 3'd5);
        @(negedge clk);
        req_valid = 2'b00;
        set_req(1, 2'b00, 3'd4, 3'd0);
        req_valid[1] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (rsp_valid) got = 1'b1;
            else @(negedge clk);
        end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_hi, rsp_lo, rsp_err} !== {1'b1, 1'b0, m_hi, m_lo, 1'b0} || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold%0d got=v%0d id%0d %0d/%0d rdy%b exp=v1 id0 %0d/%0d rdy00", j, rsp_valid, rsp_id, rsp_hi, rsp_lo, req_ready, m_hi, m_lo);
            end
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_next_accept got=%b exp=10", req_ready); end
        acc = cyc;
        m_last = 1'b1;
        model_op(2'b00, 3'd4, 3'd0);
        @(negedge clk);
        req_valid = 2'b00;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (rsp_valid) got = 1'b1;
            else @(negedge clk);
        end
        lat = cyc - acc;
        checks++; if (!got || lat != 4 || {rsp_id, rsp_hi, rsp_lo} !== {1'b1, m_hi, m_lo}) begin errors++; $display("FAIL bp_second_rsp got=lat%0d id%0d %0d/%0d exp=lat4 id1 %0d/%0d", lat, rsp_id, rsp_hi, rsp_lo, m_hi, m_lo); end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int gnt, lat, snap; logic [N-1:0] hi, lo; logic err, rid; bit to;
        run_op(0, 2'b10, 3'd5, 3'd6, gnt, lat, hi, lo, err, rid, to);
        m_last = 1'b0;
        model_op(2'b10, 3'd5, 3'd6);
        snap = dz_issue_seen;
        run_op(0, 2'b11, 3'd7, 3'd0, gnt, lat, hi, lo, err, rid, to);
        model_op(2'b11, 3'd7, 3'd0);
        checks++; if (to || {hi, lo} !== {m_hi, m_lo} || {hi, lo} !== {3'd3, 3'd6}) begin errors++; $display("FAIL dz_data got=%0d/%0d exp=3/6", hi, lo); end
        checks++; if (err !== TRAP) begin errors++; $display("FAIL dz_err got=%0d exp=%0d", err, TRAP); end
        checks++; if (lat != (TRAP ? 3 : 4)) begin errors++; $display("FAIL dz_lat got=%0d exp=%0d", lat, TRAP ? 3 : 4); end
        checks++; if (dz_issue_seen - snap != (TRAP ? 0 : 1)) begin errors++; $display("FAIL dz_issue_count got=%0d exp=%0d", dz_issue_seen - snap, TRAP ? 0 : 1); end
    endtask

    task automatic test_reset_midop();
        int gnt, lat, rsp_seen; logic [N-1:0] hi, lo; logic err, rid; bit to, got;
        set_req(0, 2'b10, 3'd6, 3'd6);
        req_valid = 2'b01;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (req_ready != 2'b00) got = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if ({rsp_valid, core_F} !== 5'b0_0001 || core_a !== '0) begin errors++; $display("FAIL midreset_state got=v%0d F%b a%0d exp=v0 F0001 a0", rsp_valid, core_F, core_a); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rsp_seen = 0;
        for (int j = 0; j < 6; j++) begin
            #1;
            if (rsp_valid) rsp_seen++;
            if (j == 0) begin
                checks++; if (core_F !== 4'b0001) begin errors++; $display("FAIL midreset_init0 got=%b exp=0001", core_F); end
            end
            if (j == 1) begin
                checks++; if (core_F !== 4'b0011) begin errors++; $display("FAIL midreset_init1 got=%b exp=0011", core_F); end
            end
            @(negedge clk);
        end
        checks++; if (rsp_seen != 0) begin errors++; $display("FAIL midreset_no_rsp got=%0d exp=0", rsp_seen); end
        run_op(1, 2'b10, 3'd7, 3'd7, gnt, lat, hi, lo, err, rid, to);
        m_last = 1'b1;
        model_op(2'b10, 3'd7, 3'd7);
        checks++; if (to || {rid, hi, lo} !== {1'b1, m_hi, m_lo}) begin errors++; $display("FAIL midreset_next_op got=%0d/%0d/%0d exp=1/%0d/%0d", rid, hi, lo, m_hi, m_lo); end
    endtask

    task automatic test_random();
        logic [1:0]   mask, rop[2];
        logic [N-1:0] ra[2], rb[2];
        logic         exp_g, exp_err;
        int           acc, lat, snap;
        bit           got;
        snap = both_ready_seen;
        for (int it = 0; it < 40; it++) begin
            mask = 2'($urandom_range(1, 3));
            for (int i = 0; i < 2; i++) begin
                rop[i] = 2'($urandom_range(0, 3));
                ra[i]  = N'($urandom);
                rb[i]  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
                set_req(i, rop[i], ra[i], rb[i]);
            end
            req_valid = mask;
            exp_g = (mask == 2'b11) ? ~m_last : mask[1];
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                #1;
                if (req_ready != 2'b00) got = 1'b1;
                else @(negedge clk);
            end
            checks++; if (req_ready !== (exp_g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rand%0d_grant got=%b exp=%b", it, req_ready, exp_g ? 2'b10 : 2'b01); end
            acc = cyc;
            m_last = exp_g;
            model_op(rop[exp_g], ra[exp_g], rb[exp_g]);
            exp_err = TRAP && rop[exp_g] == 2'b11 && rb[exp_g] == '0;
            @(negedge clk);
            req_valid = 2'b00;
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                #1;
                if (rsp_valid) got = 1'b1;
                else @(negedge clk);
            end
            lat = cyc - acc;
            checks++;
            if (!got || {rsp_id, rsp_hi, rsp_lo, rsp_err} !== {exp_g, m_hi, m_lo, exp_err} || lat != (exp_err ? 3 : 4)) begin
                errors++;
                $display("FAIL rand%0d_rsp got=id%0d %0d/%0d err%0d lat%0d exp=id%0d %0d/%0d err%0d lat%0d",
                         it, rsp_id, rsp_hi, rsp_lo, rsp_err, lat, exp_g, m_hi, m_lo, exp_err, exp_err ? 3 : 4);
            end
            @(negedge clk);
        end
        checks++; if (both_ready_seen != snap) begin errors++; $display("FAIL rand_ready_onehot got=%0d exp=%0d", both_ready_seen, snap); end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        req_op0 = '0; req_op1 = '0;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        model_reset();
        test_reset();
        test_mult();
        test_div();
        test_arbitration();
        test_backpressure();
        test_div_zero();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
